uart_tx_serializer: RTL
=======================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the baud tick generator. It consumes the one-cycle transmit baud tick and turns a parallel byte, accepted over a valid/ready handshake, into an asynchronous serial frame on `tx`. The frame is a start bit, LSB-first data, optional parity, then one or two stop bits. Each bit lasts exactly one tick period.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk pulse per bit period, from the generator's transmit tick output.
- tx_data  input  DATA_BITS  byte to send; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte; high exactly when state is IDLE.
- tx  output  1  serial line; idle level 1.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-clk pulse on the cycle the FSM returns to IDLE.

## Operation
- FSM states: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - On tx_valid && tx_ready: latch tx_data into the shift register, compute the parity bit, go to SYNC.
- SYNC: waits for the next baud_tick. On that tick: tx<=0, go to START.
- START: on baud_tick, tx<=shift[0], bit_cnt<=0, go to DATA.
- DATA: on baud_tick:
  - If bit_cnt==DATA_BITS-1: go to PARITY with tx<=parity when PARITY_MODE!=0, otherwise go to STOP with tx<=1.
  - Otherwise: shift right, tx<=next bit, bit_cnt++.
- PARITY: on baud_tick, tx<=1, stop_cnt<=0, go to STOP.
- STOP: on baud_tick:
  - If stop_cnt==STOP_BITS-1: go to IDLE and pulse done.
  - Otherwise: stop_cnt++.
- Parity bit: even = XOR-reduce of the data; odd = inverted XOR-reduce.
- Counter widths: bit_cnt is $clog2(DATA_BITS) bits; stop_cnt is 1 bit.
- baud_tick is ignored in IDLE.
- tx_data and tx_valid are ignored outside IDLE. Changing tx_data mid-frame has no effect.

## Timing
- Reset values: tx=1, tx_ready=1, busy=0, done=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: frame is abandoned and tx returns to 1 asynchronously. There is no resume.
- All outputs are registered. tx changes on the clk edge where baud_tick=1 is sampled.
- Acceptance and baud_tick in the same cycle: only the acceptance takes effect. The start bit begins on the next tick.
- Latency:
  - Acceptance to start bit: 1 to T+1 clocks, where T is the tick period.
  - Each bit: exactly T clocks.
- Frame length in tick periods: 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS.
- Back-to-back frames:
  - tx_ready rises the cycle after the final stop tick.
  - A byte accepted then starts on the following tick. The line therefore stays high at least STOP_BITS full periods.
- busy falls and done pulses in the same cycle tx_ready rises.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - FSM state encodings;
  - the baud select encodings shared with the generator.
- No sub-module: FSM, shift register and counters live in one module.
- The top level instantiates the baud generator and this block side by side, connecting the transmit tick to baud_tick.

## Test plan
Unless stated otherwise, the bench drives baud_tick every 8 clks.
- 8N1, send 0xA5 -> tx per tick period: 0, 1,0,1,0,0,1,0,1, 1. done pulses once. Frame lasts 80 clks from the start bit.
- 8E1 with 0xA5 -> parity bit 0. 8O1 with 0xA5 -> parity bit 1. 8E1 with 0x07 -> parity bit 1. All frames are 11 periods.
- STOP_BITS=2 with tx_valid held high, two bytes 0x00 then 0xFF -> second start bit begins no earlier than 2 tick periods after the first frame's last data bit ends. tx_ready is low throughout each frame.
- Assert tx_valid in the same cycle as baud_tick while IDLE -> tx stays 1 for that tick. Start bit appears at the next tick, 8 clks later.
- Assert reset during data bit 3 of 0x3C -> tx=1, tx_ready=1, busy=0 immediately. After release, a new byte 0x55 transmits correctly.
- Change tx_data from 0x12 to 0xFF mid-frame, and pulse baud_tick while IDLE with no valid -> serialized bits still match 0x12. No frame starts from the idle ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM states, baud select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    // Baud select codes, common to the tick generator and its register map.
    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_sel_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: byte in over valid/ready, start/data/parity/stop frame out on tx.
// Latency: start bit 1..T+1 clks after acceptance, then one bit per baud_tick period.
// Backpressure: tx_ready high only in IDLE; tx_valid/tx_data ignored for the rest of the frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 par_q, par_nxt;
    logic                 tx_nxt;
    logic                 done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift_q  <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            par_q    <= par_nxt;
            tx       <= tx_nxt;
            done     <= done_nxt;
            // Handshake flags are registered copies of the next state so they track it exactly.
            tx_ready <= (state_nxt == ST_IDLE);
            busy     <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par_q;
        tx_nxt       = tx;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                // A tick landing on the acceptance cycle is deliberately ignored: SYNC waits for the next one.
                if (tx_valid && tx_ready) begin
                    shift_nxt    = tx_data;
                    par_nxt      = (PARITY_MODE == PAR_ODD) ? ~^tx_data : ^tx_data;
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (baud_tick) begin
                    tx_nxt    = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_nxt      = shift_q[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            tx_nxt    = par_q;
                            state_nxt = ST_PARITY;
                        end else begin
                            tx_nxt       = 1'b1;
                            stop_cnt_nxt = 1'b0;
                            state_nxt    = ST_STOP;
                        end
                    end else begin
                        shift_nxt   = shift_q >> 1;
                        tx_nxt      = shift_q[1];
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
